// File: rtl/lot_pkg.sv
// Shared definitions for the lottery round sequencer: state codes, digit limit, prize codes.
package lot_pkg;

   // Codes are exported on the debug state LEDs, so the values are fixed.
   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StEntry   = 4'd1,
      StWaitFim = 4'd2,
      StCheck   = 4'd3,
      StResult  = 4'd4
   } state_e;

   localparam int unsigned DIGIT_MAX = 9;
   localparam int unsigned NPLAYERS  = 2;

   localparam logic [1:0] PRZ_NONE = 2'd0;
   localparam logic [1:0] PRZ_1    = 2'd1;
   localparam logic [1:0] PRZ_2    = 2'd2;

   // True when the switch value is a legal BCD digit.
   function automatic logic digit_ok(input logic [3:0] d);
      return d <= 4'(DIGIT_MAX);
   endfunction

endpackage

// File: rtl/lot_round_ctrl_if.sv
// Board, ticket-register and comparator signals of the round sequencer.
// slave: the sequencer itself; master: the board/comparator side driving it.
interface lot_round_ctrl_if #(
   parameter int unsigned DIGITS = 5
);
   localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Board inputs
   logic [0:3]    num;
   logic          insere;
   logic          fim;
   logic          fim_jogo;
   // Ticket register write port
   logic          dig_we;
   logic [AW-1:0] dig_addr;
   logic [0:3]    dig_data;
   // Prize comparator handshake
   logic          cmp_start;
   logic          cmp_done;
   logic [0:1]    cmp_prize;
   // Status LEDs
   logic          player;
   logic [0:1]    ledp1;
   logic [0:1]    ledp2;
   logic          led15;
   logic          err;
   logic [0:3]    state;

   modport slave (
      input  num, insere, fim, fim_jogo, cmp_done, cmp_prize,
      output dig_we, dig_addr, dig_data, cmp_start,
      output player, ledp1, ledp2, led15, err, state
   );

   modport master (
      output num, insere, fim, fim_jogo, cmp_done, cmp_prize,
      input  dig_we, dig_addr, dig_data, cmp_start,
      input  player, ledp1, ledp2, led15, err, state
   );

endinterface

// File: rtl/lot_timeout_cnt.sv
// Loadable saturating down-counter; expired_o is high once the count reaches zero.
module lot_timeout_cnt #(
   parameter int unsigned Width = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             expired_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   // Load has priority over decrement; decrement stops at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - Width'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/lot_round_ctrl.sv
// Lottery round sequencer: collects each player's BCD ticket into the ticket register,
// kicks the prize comparator, latches prizes onto the player LEDs and flags round end.
module lot_round_ctrl
   import lot_pkg::*;
#(
   parameter int unsigned DIGITS      = 5,
   parameter int unsigned CMP_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   lot_round_ctrl_if.slave  bus
);

   localparam int unsigned AW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned TW = (CMP_TIMEOUT > 1) ? $clog2(CMP_TIMEOUT) : 1;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          player_q, player_d;
   logic [1:0]    ledp1_q, ledp1_d;
   logic [1:0]    ledp2_q, ledp2_d;
   logic          led15_q, led15_d;
   logic          err_q, err_d;
   logic          dig_we_q, dig_we_d;
   logic [AW-1:0] dig_addr_q, dig_addr_d;
   logic [3:0]    dig_data_q, dig_data_d;
   logic          cmp_start_q, cmp_start_d;

   logic          cnt_full;
   logic          take_digit;
   logic          latch_prize;
   logic [1:0]    prize_val;
   logic          tmo_load;
   logic          tmo_dec;
   logic          tmo_expired;

   assign cnt_full = (cnt_q == CW'(DIGITS));

   // Loaded with CMP_TIMEOUT-1 so that expiry is seen on the CMP_TIMEOUT-th edge in CHECK.
   lot_timeout_cnt #(
      .Width (TW)
   ) u_timeout (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmo_load),
      .load_val_i (TW'(CMP_TIMEOUT - 1)),
      .dec_i      (tmo_dec),
      .expired_o  (tmo_expired)
   );

   // Next-state, digit capture and prize latching.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      player_d    = player_q;
      ledp1_d     = ledp1_q;
      ledp2_d     = ledp2_q;
      led15_d     = led15_q;
      err_d       = err_q;
      dig_we_d    = 1'b0;
      dig_addr_d  = dig_addr_q;
      dig_data_d  = dig_data_q;
      cmp_start_d = 1'b0;
      tmo_load    = 1'b0;
      tmo_dec     = 1'b0;
      take_digit  = 1'b0;
      latch_prize = 1'b0;
      prize_val   = PRZ_NONE;

      case (state_q)
         StIdle: begin
            if (bus.insere) begin
               state_d    = StEntry;
               err_d      = 1'b0;
               take_digit = 1'b1;
               // First digit of player 0 after a finished round starts a new round.
               if (led15_q && !player_q) begin
                  ledp1_d = PRZ_NONE;
                  ledp2_d = PRZ_NONE;
                  led15_d = 1'b0;
               end
            end
         end
         StEntry: begin
            // insere outranks fim here, so fim is simply not looked at.
            if (bus.insere) begin
               take_digit = 1'b1;
            end else begin
               state_d = StWaitFim;
            end
         end
         StWaitFim: begin
            if (bus.insere) begin
               state_d    = StEntry;
               take_digit = 1'b1;
            end else if (bus.fim) begin
               if (cnt_full) begin
                  state_d     = StCheck;
                  cmp_start_d = 1'b1;
                  tmo_load    = 1'b1;
               end else begin
                  // Short ticket: no comparison, zero prize.
                  state_d     = StResult;
                  latch_prize = 1'b1;
                  err_d       = 1'b1;
               end
            end
         end
         StCheck: begin
            tmo_dec = 1'b1;
            if (bus.cmp_done) begin
               state_d     = StResult;
               latch_prize = 1'b1;
               prize_val   = bus.cmp_prize;
            end else if (tmo_expired) begin
               state_d     = StResult;
               latch_prize = 1'b1;
               err_d       = 1'b1;
            end
         end
         StResult: begin
            if (bus.fim_jogo) begin
               state_d  = StIdle;
               cnt_d    = '0;
               player_d = (player_q == 1'(NPLAYERS - 1)) ? 1'b0 : ~player_q;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Bad digits and digits beyond the ticket length are dropped and flagged.
      if (take_digit) begin
         if (!digit_ok(bus.num) || cnt_full) begin
            err_d = 1'b1;
         end else begin
            dig_we_d   = 1'b1;
            dig_addr_d = AW'(cnt_q);
            dig_data_d = bus.num;
            cnt_d      = cnt_q + CW'(1);
         end
      end

      if (latch_prize) begin
         if (player_q) begin
            ledp2_d = prize_val;
            led15_d = 1'b1;
         end else begin
            ledp1_d = prize_val;
         end
      end
   end

   // State and registered outputs; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         player_q    <= 1'b0;
         ledp1_q     <= PRZ_NONE;
         ledp2_q     <= PRZ_NONE;
         led15_q     <= 1'b0;
         err_q       <= 1'b0;
         dig_we_q    <= 1'b0;
         dig_addr_q  <= '0;
         dig_data_q  <= '0;
         cmp_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         player_q    <= player_d;
         ledp1_q     <= ledp1_d;
         ledp2_q     <= ledp2_d;
         led15_q     <= led15_d;
         err_q       <= err_d;
         dig_we_q    <= dig_we_d;
         dig_addr_q  <= dig_addr_d;
         dig_data_q  <= dig_data_d;
         cmp_start_q <= cmp_start_d;
      end
   end

   assign bus.dig_we    = dig_we_q;
   assign bus.dig_addr  = dig_addr_q;
   assign bus.dig_data  = dig_data_q;
   assign bus.cmp_start = cmp_start_q;
   assign bus.player    = player_q;
   assign bus.ledp1     = ledp1_q;
   assign bus.ledp2     = ledp2_q;
   assign bus.led15     = led15_q;
   assign bus.err       = err_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_lot_round_ctrl.sv
// Directed bench for lot_round_ctrl with a simple prize-comparator model.
module tb_lot_round_ctrl;
   import lot_pkg::*;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   lot_round_ctrl_if #(.DIGITS(5)) bus ();

   lot_round_ctrl #(
      .DIGITS      (5),
      .CMP_TIMEOUT (15)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Comparator model controls
   bit         model_en    = 1'b0;
   int         model_delay = 3;
   logic [1:0] model_prize = 2'd0;

   // Write / start log filled by the monitor
   int         wr_n    = 0;
   int         start_n = 0;
   logic [3:0] wr_addr [64];
   logic [3:0] wr_data [64];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_digit(input logic [3:0] d);
      bus.insere = 1'b1;
      bus.num    = d;
      step();
   endtask

   task automatic end_entry();
      bus.insere = 1'b0;
      step();
   endtask

   task automatic press_fim();
      bus.fim = 1'b1;
      step();
      bus.fim = 1'b0;
   endtask

   task automatic next_player();
      bus.fim_jogo = 1'b1;
      step();
      bus.fim_jogo = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [3:0] s, input int budget);
      int k = 0;
      while (bus.state !== s && k < budget) begin
         step();
         k++;
      end
      check_eq(tag, bus.state, s);
   endtask

   task automatic check_writes(input string tag, input int base, input logic [3:0] e0,
                               input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3,
                               input logic [3:0] e4);
      logic [3:0] exp [5];
      exp = '{e0, e1, e2, e3, e4};
      check_eq({tag, "_nwr"}, wr_n - base, 5);
      for (int i = 0; i < 5; i++) begin
         if (base + i < 64) begin
            check_eq($sformatf("%s_a%0d", tag, i), wr_addr[base + i], i);
            check_eq($sformatf("%s_d%0d", tag, i), wr_data[base + i], exp[i]);
         end
      end
   endtask

   // Monitor: log every write strobe and comparator start, mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.dig_we === 1'b1) begin
            if (wr_n < 64) begin
               wr_addr[wr_n] = 4'(bus.dig_addr);
               wr_data[wr_n] = bus.dig_data;
            end
            wr_n++;
         end
         if (bus.cmp_start === 1'b1) start_n++;
      end
   end

   // Comparator model: answers model_delay clocks after cmp_start.
   initial begin
      bus.cmp_done  = 1'b0;
      bus.cmp_prize = 2'd0;
      forever begin
         @(negedge clk);
         if (bus.cmp_start === 1'b1 && model_en) begin
            repeat (model_delay - 1) @(negedge clk);
            bus.cmp_done  = 1'b1;
            bus.cmp_prize = model_prize;
            @(negedge clk);
            bus.cmp_done  = 1'b0;
            bus.cmp_prize = 2'd0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      int sbase;
      reset        = 1'b1;
      bus.num      = 4'd0;
      bus.insere   = 1'b0;
      bus.fim      = 1'b0;
      bus.fim_jogo = 1'b0;
      step();
      step();
      check_eq("rst_state", bus.state, 0);
      check_eq("rst_we", bus.dig_we, 0);
      check_eq("rst_start", bus.cmp_start, 0);
      check_eq("rst_player", bus.player, 0);
      check_eq("rst_leds", {bus.ledp1, bus.ledp2, bus.led15, bus.err}, 0);
      reset = 1'b0;

      // 1: player 0 ticket 4,7,0,1,0 -> prize 1 after 3 clocks
      model_en = 1'b1; model_delay = 3; model_prize = PRZ_1;
      base = wr_n; sbase = start_n;
      put_digit(4'd4);
      check_eq("t1_state_entry", bus.state, 1);
      check_eq("t1_we0", bus.dig_we, 1);
      check_eq("t1_addr0", bus.dig_addr, 0);
      check_eq("t1_data0", bus.dig_data, 4);
      put_digit(4'd7); put_digit(4'd0); put_digit(4'd1); put_digit(4'd0);
      end_entry();
      check_eq("t1_state_wait", bus.state, 2);
      next_player();
      check_eq("t1_fimjogo_ign_state", bus.state, 2);
      check_eq("t1_fimjogo_ign_player", bus.player, 0);
      press_fim();
      check_eq("t1_state_check", bus.state, 3);
      check_eq("t1_start_hi", bus.cmp_start, 1);
      step();
      check_eq("t1_start_lo", bus.cmp_start, 0);
      check_eq("t1_no_early_prize", bus.ledp1, 0);
      step();
      check_eq("t1_still_check", bus.state, 3);
      step();
      check_eq("t1_state_result", bus.state, 4);
      check_eq("t1_ledp1", bus.ledp1, 1);
      check_eq("t1_led15", bus.led15, 0);
      check_eq("t1_err", bus.err, 0);
      check_eq("t1_nstart", start_n - sbase, 1);
      check_writes("t1", base, 4'd4, 4'd7, 4'd0, 4'd1, 4'd0);

      // 2: player 1 ticket 6,7,0,3,9 -> prize 2; fim alongside insere is ignored
      next_player();
      check_eq("t2_player", bus.player, 1);
      check_eq("t2_state_idle", bus.state, 0);
      model_prize = PRZ_2;
      base = wr_n;
      put_digit(4'd6); put_digit(4'd7); put_digit(4'd0); put_digit(4'd3);
      bus.fim = 1'b1;
      put_digit(4'd9);
      bus.fim = 1'b0;
      check_eq("t2_insere_wins", bus.state, 1);
      end_entry();
      press_fim();
      wait_state("t2_result", 4'd4, 10);
      check_eq("t2_ledp2", bus.ledp2, 2);
      check_eq("t2_led15", bus.led15, 1);
      check_eq("t2_ledp1_kept", bus.ledp1, 1);
      check_writes("t2", base, 4'd6, 4'd7, 4'd0, 4'd3, 4'd9);

      // 3: new round, first digit clears the LEDs on the same edge
      next_player();
      check_eq("t3_player", bus.player, 0);
      check_eq("t3_led15_held", bus.led15, 1);
      put_digit(4'd4);
      check_eq("t3_ledp1_clr", bus.ledp1, 0);
      check_eq("t3_ledp2_clr", bus.ledp2, 0);
      check_eq("t3_led15_clr", bus.led15, 0);
      put_digit(4'd1); put_digit(4'd2); put_digit(4'd3); put_digit(4'd4);
      end_entry();
      model_prize = PRZ_NONE; model_delay = 2;
      press_fim();
      wait_state("t3_result", 4'd4, 10);
      check_eq("t3_ledp1", bus.ledp1, 0);
      check_eq("t3_led15", bus.led15, 0);
      next_player();

      // 4: player 1 ticket 2,3,A,1,1,9 then extra 7
      base = wr_n;
      put_digit(4'd2); put_digit(4'd3);
      check_eq("t4_err_before", bus.err, 0);
      put_digit(4'hA);
      check_eq("t4_bad_no_we", bus.dig_we, 0);
      check_eq("t4_bad_err", bus.err, 1);
      put_digit(4'd1); put_digit(4'd1); put_digit(4'd9);
      put_digit(4'd7);
      check_eq("t4_extra_no_we", bus.dig_we, 0);
      end_entry();
      check_writes("t4", base, 4'd2, 4'd3, 4'd1, 4'd1, 4'd9);
      model_prize = PRZ_1; model_delay = 3;
      press_fim();
      wait_state("t4_result", 4'd4, 10);
      check_eq("t4_ledp2", bus.ledp2, 1);
      check_eq("t4_led15", bus.led15, 1);
      check_eq("t4_err_sticky", bus.err, 1);
      next_player();

      // 5: player 0 enters only 3 digits
      put_digit(4'd5);
      check_eq("t5_err_clr", bus.err, 0);
      put_digit(4'd5); put_digit(4'd5);
      end_entry();
      sbase = start_n;
      press_fim();
      check_eq("t5_state_result", bus.state, 4);
      check_eq("t5_start_lo", bus.cmp_start, 0);
      step(); step();
      check_eq("t5_nstart", start_n - sbase, 0);
      check_eq("t5_ledp1", bus.ledp1, 0);
      check_eq("t5_err", bus.err, 1);
      check_eq("t5_led15", bus.led15, 0);
      next_player();

      // 6: player 1, comparator answers only after the timeout
      model_delay = 17; model_prize = PRZ_2;
      put_digit(4'd1); put_digit(4'd2); put_digit(4'd3); put_digit(4'd4); put_digit(4'd5);
      end_entry();
      press_fim();
      check_eq("t6_state_check", bus.state, 3);
      repeat (14) step();
      check_eq("t6_hold_check", bus.state, 3);
      step();
      check_eq("t6_tmo_result", bus.state, 4);
      check_eq("t6_tmo_err", bus.err, 1);
      check_eq("t6_tmo_ledp2", bus.ledp2, 0);
      check_eq("t6_tmo_led15", bus.led15, 1);
      repeat (4) step();
      check_eq("t6_late_ign_ledp2", bus.ledp2, 0);
      check_eq("t6_late_ign_state", bus.state, 4);

      // Reset in CHECK aborts the round; reset beats insere
      next_player();
      model_en = 1'b0;
      put_digit(4'd1); put_digit(4'd2); put_digit(4'd3); put_digit(4'd4); put_digit(4'd5);
      end_entry();
      press_fim();
      check_eq("t7_state_check", bus.state, 3);
      step();
      reset      = 1'b1;
      bus.insere = 1'b1;
      bus.num    = 4'd3;
      step();
      check_eq("t7_rst_state", bus.state, 0);
      check_eq("t7_rst_we", bus.dig_we, 0);
      check_eq("t7_rst_addr", bus.dig_addr, 0);
      check_eq("t7_rst_data", bus.dig_data, 0);
      check_eq("t7_rst_player", bus.player, 0);
      check_eq("t7_rst_leds", {bus.ledp1, bus.ledp2, bus.led15, bus.err}, 0);
      bus.insere = 1'b0;
      reset      = 1'b0;
      sbase = start_n;
      repeat (20) step();
      check_eq("t7_no_start", start_n - sbase, 0);
      check_eq("t7_idle", bus.state, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
